// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV64 decode stage with ID/EX pipeline register
module id_ex_stage #(
   parameter int XLEN = 64,
   parameter int PC_W = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_id_valid,
   input  logic [PC_W-1:0] if_id_pc,
   input  logic [31:0]     if_id_instr,
   output logic [4:0]      rf_rs1_addr,
   output logic [4:0]      rf_rs2_addr,
   input  logic [XLEN-1:0] rf_rs1_data,
   input  logic [XLEN-1:0] rf_rs2_data,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd_addr,
   input  logic [XLEN-1:0] wb_rd_data,
   input  logic            ex_flush,
   output logic            stall_if_id,
   output logic            ex_valid,
   output logic [PC_W-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1_addr,
   output logic [4:0]      ex_rs2_addr,
   output logic [4:0]      ex_rd_addr,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7_5,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write
);

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;

   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd;
   logic            known, use_rs1, use_rs2, writes_rd, is_load, is_store;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
   logic [XLEN-1:0] opnd1, opnd2;
   logic            load_use, bubble;

   assign opcode      = if_id_instr[6:0];
   assign rs1         = if_id_instr[19:15];
   assign rs2         = if_id_instr[24:20];
   assign rd          = if_id_instr[11:7];
   assign rf_rs1_addr = rs1;
   assign rf_rs2_addr = rs2;

   assign imm_i = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:20]};
   assign imm_s = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
   assign imm_b = {{(XLEN-13){if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                   if_id_instr[30:25], if_id_instr[11:8], 1'b0};
   assign imm_u = {{(XLEN-32){if_id_instr[31]}}, if_id_instr[31:12], 12'b0};
   assign imm_j = {{(XLEN-21){if_id_instr[31]}}, if_id_instr[31], if_id_instr[19:12],
                   if_id_instr[20], if_id_instr[30:21], 1'b0};

   // Opcode decode: operand usage, write-back class and immediate format
   always_comb begin
      known     = 1'b1;
      use_rs1   = 1'b1;
      use_rs2   = 1'b0;
      writes_rd = 1'b1;
      is_load   = 1'b0;
      is_store  = 1'b0;
      imm       = '0;
      case (opcode)
         OPC_LOAD: begin
            is_load = 1'b1;
            imm     = imm_i;
         end
         OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: imm = imm_i;
         OPC_STORE: begin
            use_rs2   = 1'b1;
            writes_rd = 1'b0;
            is_store  = 1'b1;
            imm       = imm_s;
         end
         OPC_BRANCH: begin
            use_rs2   = 1'b1;
            writes_rd = 1'b0;
            imm       = imm_b;
         end
         OPC_LUI, OPC_AUIPC: begin
            use_rs1 = 1'b0;
            imm     = imm_u;
         end
         OPC_JAL: begin
            use_rs1 = 1'b0;
            imm     = imm_j;
         end
         OPC_OP, OPC_OP_32: use_rs2 = 1'b1;
         default: begin
            known     = 1'b0;
            use_rs1   = 1'b0;
            writes_rd = 1'b0;
         end
      endcase
   end

   // Operand select: x0 is hard zero, a same-cycle WB write wins over the stale file value
   always_comb begin
      opnd1 = rf_rs1_data;
      opnd2 = rf_rs2_data;
      if (rs1 == 5'd0)
         opnd1 = '0;
      else if (wb_reg_write && wb_rd_addr == rs1)
         opnd1 = wb_rd_data;
      if (rs2 == 5'd0)
         opnd2 = '0;
      else if (wb_reg_write && wb_rd_addr == rs2)
         opnd2 = wb_rd_data;
   end

   // Load-use detection against the load currently sitting in EX
   always_comb begin
      load_use = if_id_valid && known && ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) &&
                 ((use_rs1 && rs1 == ex_rd_addr) || (use_rs2 && rs2 == ex_rd_addr));
      stall_if_id = load_use && !ex_flush && !rst;
      bubble      = ex_flush || load_use || !if_id_valid || !known;
   end

   // ID/EX register: reset and bubbles clear every field
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_rs1_addr  <= '0;
         ex_rs2_addr  <= '0;
         ex_rd_addr   <= '0;
         ex_opcode    <= '0;
         ex_funct3    <= '0;
         ex_funct7_5  <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
      end else begin
         ex_valid     <= 1'b1;
         ex_pc        <= if_id_pc;
         ex_rs1_data  <= opnd1;
         ex_rs2_data  <= opnd2;
         ex_imm       <= imm;
         ex_rs1_addr  <= rs1;
         ex_rs2_addr  <= rs2;
         ex_rd_addr   <= rd;
         ex_opcode    <= opcode;
         ex_funct3    <= if_id_instr[14:12];
         ex_funct7_5  <= if_id_instr[30];
         ex_reg_write <= writes_rd && (rd != 5'd0);
         ex_mem_read  <= is_load;
         ex_mem_write <= is_store;
      end
   end

endmodule
